game_sequencer: RTL



---
 rtl/game_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Pong flow controller: game-tick divider, pause synchronizer and the INIT/SERVE/PLAY/PAUSE/WIN sequencer.
// Define PAUSE_DEBOUNCE_EN to debounce the synchronized pause button before edge detection.
module game_sequencer #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int TICK_RATE       = 50,
  parameter int SERVE_TICKS     = 50,
  parameter int WIN_CYCLES      = 350000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       pause,
  input  logic       p1_scored,
  input  logic       p2_scored,
  input  logic       p1_wins,
  input  logic       p2_wins,
  output logic       game_tick,
  output logic       game_reset,
  output logic       paused,
  output logic [2:0] state
);

  localparam int DIV     = CLOCK_FREQ / TICK_RATE;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SERVE_W = $clog2(SERVE_TICKS + 1);
  localparam int WIN_W   = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_CYCLES - 1);

  if (DIV < 2) begin : g_bad_div
    $error("game_sequencer: CLOCK_FREQ/TICK_RATE must be at least 2");
  end
  if (SERVE_TICKS < 1 || WIN_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_count
    $error("game_sequencer: SERVE_TICKS, WIN_CYCLES and DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_WIN   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               r_saved;
  logic                 r_game_tick;
  logic                 r_game_reset;
  logic                 r_paused;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [SERVE_W-1:0]   r_serve_cnt;
  logic [WIN_W-1:0]     r_win_cnt;
  logic                 r_pause_meta;
  logic                 r_pause_sync;
  logic                 r_score_any;
  logic                 r_score_evt;

  logic                 w_base_tick;
  logic                 w_pause_press;
  logic                 w_score_any;
  logic                 w_wins;

  assign w_base_tick = (r_div_cnt == DIV_LAST);
  assign w_score_any = p1_scored | p2_scored;
  assign w_wins      = p1_wins | p2_wins;

  // NOTE: two back-to-back flops with no logic between them; the second is the first one safe to use.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_pause_meta <= 1'b0;
      r_pause_sync <= 1'b0;
    end else begin
      r_pause_meta <= pause;
      r_pause_sync <= r_pause_meta;
    end
  end

`ifdef PAUSE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_pause_level;
  logic            r_pause_level_d;

  // The level follows the raw input only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_db_cnt        <= '0;
      r_pause_level   <= 1'b0;
      r_pause_level_d <= 1'b0;
    end else begin
      r_pause_level_d <= r_pause_level;
      if (r_pause_sync == r_pause_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_pause_level <= r_pause_sync;
        r_db_cnt      <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_pause_press = r_pause_level & ~r_pause_level_d;
`else
  logic r_pause_sync_d;

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_pause_sync_d <= 1'b0;
    end else begin
      r_pause_sync_d <= r_pause_sync;
    end
  end

  assign w_pause_press = r_pause_sync & ~r_pause_sync_d;
`endif

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_score_any <= 1'b0;
      r_score_evt <= 1'b0;
    end else begin
      r_score_any <= w_score_any;
      r_score_evt <= w_score_any & ~r_score_any;
    end
  end

  // Free-running outside INIT so a pause never shifts the tick phase.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_div_cnt <= '0;
    end else if (r_state == ST_INIT || w_base_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      r_state      <= ST_INIT;
      r_saved      <= ST_SERVE;
      r_game_tick  <= 1'b0;
      r_game_reset <= 1'b0;
      r_paused     <= 1'b0;
      r_serve_cnt  <= '0;
      r_win_cnt    <= '0;
    end else begin
      r_game_tick  <= w_base_tick && (r_state == ST_PLAY);
      r_game_reset <= 1'b0;
      r_paused     <= 1'b0;
      case (r_state)
        // INIT holds until its game_reset pulse has been issued, then serves.
        ST_INIT: begin
          r_serve_cnt <= '0;
          r_win_cnt   <= '0;
          if (r_game_reset) begin
            r_state <= ST_SERVE;
          end else begin
            r_game_reset <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (w_wins) begin
            r_state <= ST_WIN;
          end else if (w_pause_press) begin
            r_state  <= ST_PAUSE;
            r_saved  <= ST_SERVE;
            r_paused <= 1'b1;
          end else if (w_base_tick) begin
            if (r_serve_cnt == SERVE_LAST) begin
              r_state     <= ST_PLAY;
              r_serve_cnt <= '0;
            end else begin
              r_serve_cnt <= r_serve_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (w_wins) begin
            r_state <= ST_WIN;
          end else if (r_score_evt) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
          end else if (w_pause_press) begin
            r_state  <= ST_PAUSE;
            r_saved  <= ST_PLAY;
            r_paused <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (w_wins) begin
            r_state <= ST_WIN;
          end else if (w_pause_press) begin
            r_state <= r_saved;
          end else begin
            r_paused <= 1'b1;
          end
        end
        ST_WIN: begin
          if (r_win_cnt == WIN_LAST) begin
            r_state      <= ST_INIT;
            r_game_reset <= 1'b1;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_INIT;
          r_game_reset <= 1'b1;
        end
      endcase
    end
  end

  assign game_tick  = r_game_tick;
  assign game_reset = r_game_reset;
  assign paused     = r_paused;
  assign state      = r_state;

endmodule
